// File: rtl/csa_stream_accumulator.sv
// rtl/csa_stream_accumulator.sv - streaming carry-save accumulator with single-cycle final resolve
module csa_stream_accumulator #(
  parameter int WIDTH     = 16,
  parameter int NUM_OPS   = 9,
  parameter int SUM_WIDTH = 20,
  parameter bit SIGNED    = 1'b0,
  localparam int CW       = $clog2(NUM_OPS + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_valid,
  input  logic                 in_last,
  output logic                 in_ready,
  output logic [SUM_WIDTH-1:0] sum,
  output logic                 cout,
  output logic [CW-1:0]        op_count,
  output logic                 out_valid,
  input  logic                 out_ready
);

  typedef enum logic [1:0] {
    ACCUM   = 2'd0,
    RESOLVE = 2'd1,
    OUT     = 2'd2
  } state_t;

  state_t state, state_next;

  logic [SUM_WIDTH:0] s_reg, c_reg;
  logic [SUM_WIDTH:0] x_ext, maj, resolved;
  logic               accept, resolve, release_out, batch_end;

  assign x_ext    = {{(SUM_WIDTH + 1 - WIDTH){SIGNED ? in_data[WIDTH-1] : 1'b0}}, in_data};
  assign maj      = (s_reg & c_reg) | (s_reg & x_ext) | (c_reg & x_ext);
  assign resolved = s_reg + c_reg;

  // The NUM_OPS-th operand closes the batch even without in_last.
  assign batch_end = in_last || (op_count == CW'(NUM_OPS - 1));

  always_comb begin
    state_next  = state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    accept      = 1'b0;
    resolve     = 1'b0;
    release_out = 1'b0;
    case (state)
      ACCUM: begin
        in_ready = 1'b1;
        accept   = in_valid;
        if (in_valid && batch_end) state_next = RESOLVE;
      end
      RESOLVE: begin
        resolve    = 1'b1;
        state_next = OUT;
      end
      OUT: begin
        out_valid   = 1'b1;
        release_out = out_ready;
        if (out_ready) state_next = ACCUM;
      end
      default: state_next = ACCUM;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ACCUM;
      s_reg    <= '0;
      c_reg    <= '0;
      op_count <= '0;
      sum      <= '0;
      cout     <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        s_reg    <= s_reg ^ c_reg ^ x_ext;
        c_reg    <= {maj[SUM_WIDTH-1:0], 1'b0};
        op_count <= op_count + CW'(1);
      end
      if (resolve) begin
        sum  <= resolved[SUM_WIDTH-1:0];
        cout <= resolved[SUM_WIDTH];
      end
      // Result stays on sum/cout until the next resolve; only the running state clears.
      if (release_out) begin
        s_reg    <= '0;
        c_reg    <= '0;
        op_count <= '0;
      end
    end
  end

endmodule

// File: tb/tb_csa_stream_accumulator.sv
// tb/tb_csa_stream_accumulator.sv - self-checking bench for csa_stream_accumulator
module tb_csa_stream_accumulator;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [15:0] din  [3];
  logic        vin  [3];
  logic        lin  [3];
  logic        ordy [3];
  logic        rdy  [3];
  logic        ov   [3];
  logic        co   [3];
  logic [3:0]  oc   [3];
  logic [19:0] sum0, sum1;
  logic [15:0] sum2;
  logic [19:0] sm   [3];

  always_comb begin
    sm[0] = sum0;
    sm[1] = sum1;
    sm[2] = {4'h0, sum2};
  end

  // Instance 0: unsigned, 20-bit result. Instance 1: signed. Instance 2: 16-bit result.
  csa_stream_accumulator #(.WIDTH(16), .NUM_OPS(9), .SUM_WIDTH(20), .SIGNED(1'b0)) u0 (
    .clk(clk), .rst(rst), .in_data(din[0]), .in_valid(vin[0]), .in_last(lin[0]),
    .in_ready(rdy[0]), .sum(sum0), .cout(co[0]), .op_count(oc[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]));

  csa_stream_accumulator #(.WIDTH(16), .NUM_OPS(9), .SUM_WIDTH(20), .SIGNED(1'b1)) u1 (
    .clk(clk), .rst(rst), .in_data(din[1]), .in_valid(vin[1]), .in_last(lin[1]),
    .in_ready(rdy[1]), .sum(sum1), .cout(co[1]), .op_count(oc[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]));

  csa_stream_accumulator #(.WIDTH(16), .NUM_OPS(9), .SUM_WIDTH(16), .SIGNED(1'b0)) u2 (
    .clk(clk), .rst(rst), .in_data(din[2]), .in_valid(vin[2]), .in_last(lin[2]),
    .in_ready(rdy[2]), .sum(sum2), .cout(co[2]), .op_count(oc[2]),
    .out_valid(ov[2]), .out_ready(ordy[2]));

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] ops [16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Drives ops[0..n-1] into instance d with in_valid held high, checks the
  // result against plain integer addition, holds the result for 'hold' cycles.
  task automatic run_batch(input int d, input int n, input bit use_last, input int hold);
    longint      acc = 0;
    bit          sgn = (d == 1);
    int          sw  = (d == 2) ? 16 : 20;
    logic [19:0] esum;
    logic        ecout;
    for (int k = 0; k < n; k++) begin
      din[d] = ops[k];
      vin[d] = 1'b1;
      lin[d] = use_last && (k == n - 1);
      chk("in_ready_accum", 32'(rdy[d]), 32'd1);
      chk("op_count_accum", 32'(oc[d]), 32'(k));
      acc += sgn ? longint'($signed(ops[k])) : longint'(ops[k]);
      tick;
    end
    esum  = 20'(acc & ((64'sd1 <<< sw) - 1));
    ecout = acc[sw];
    din[d]  = 16'($urandom);
    vin[d]  = 1'b1;
    lin[d]  = 1'($urandom);
    ordy[d] = (hold == 0);
    chk("in_ready_resolve", 32'(rdy[d]), 32'd0);
    chk("out_valid_resolve", 32'(ov[d]), 32'd0);
    tick;
    chk("out_valid_out", 32'(ov[d]), 32'd1);
    chk("in_ready_out", 32'(rdy[d]), 32'd0);
    chk("sum", 32'(sm[d]), 32'(esum));
    chk("cout", 32'(co[d]), 32'(ecout));
    chk("op_count", 32'(oc[d]), 32'(n));
    for (int i = 0; i < hold; i++) begin
      tick;
      chk("hold_out_valid", 32'(ov[d]), 32'd1);
      chk("hold_in_ready", 32'(rdy[d]), 32'd0);
      chk("hold_sum", 32'(sm[d]), 32'(esum));
      chk("hold_cout", 32'(co[d]), 32'(ecout));
      chk("hold_op_count", 32'(oc[d]), 32'(n));
    end
    ordy[d] = 1'b1;
    tick;
    chk("out_valid_after", 32'(ov[d]), 32'd0);
    chk("in_ready_after", 32'(rdy[d]), 32'd1);
    chk("op_count_after", 32'(oc[d]), 32'd0);
    vin[d]  = 1'b0;
    lin[d]  = 1'b0;
    ordy[d] = 1'b0;
  endtask

  initial begin
    int d, n, hold;
    bit ul;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      din[i] = '0; vin[i] = 1'b0; lin[i] = 1'b0; ordy[i] = 1'b0;
    end
    tick;
    tick;
    for (int i = 0; i < 3; i++) begin
      chk("reset_sum", 32'(sm[i]), 32'd0);
      chk("reset_cout", 32'(co[i]), 32'd0);
      chk("reset_op_count", 32'(oc[i]), 32'd0);
      chk("reset_out_valid", 32'(ov[i]), 32'd0);
      chk("reset_in_ready", 32'(rdy[i]), 32'd1);
    end
    rst = 1'b0;
    tick;

    // Full unsigned batch closing on the 9th operand.
    for (int k = 0; k < 9; k++) ops[k] = 16'hFFFF;
    run_batch(0, 9, 1'b0, 0);

    // Early termination, then a fresh batch.
    ops[0] = 16'd1; ops[1] = 16'd2; ops[2] = 16'd3;
    run_batch(0, 3, 1'b1, 0);
    for (int k = 0; k < 4; k++) ops[k] = 16'h0010;
    run_batch(0, 4, 1'b1, 0);

    // Signed operands.
    for (int k = 0; k < 9; k++) ops[k] = 16'hFFFF;
    run_batch(1, 9, 1'b0, 0);
    ops[0] = 16'h7FFF; ops[1] = 16'h8000;
    run_batch(1, 2, 1'b1, 0);

    // Carry out of a narrow result.
    ops[0] = 16'hFFFF; ops[1] = 16'hFFFF;
    run_batch(2, 2, 1'b1, 0);

    // Result backpressure with the producer still offering data.
    ops[0] = 16'h1234; ops[1] = 16'h4321; ops[2] = 16'h0F0F;
    run_batch(0, 3, 1'b1, 5);

    // Reset in the middle of a batch discards it.
    for (int k = 0; k < 4; k++) begin
      din[0] = 16'h0100; vin[0] = 1'b1; lin[0] = 1'b0;
      tick;
    end
    #2 rst = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(ov[0]), 32'd0);
    chk("midrst_op_count", 32'(oc[0]), 32'd0);
    chk("midrst_in_ready", 32'(rdy[0]), 32'd1);
    vin[0] = 1'b0;
    tick;
    rst = 1'b0;
    tick;
    ops[0] = 16'd2; ops[1] = 16'd5;
    run_batch(0, 2, 1'b1, 0);

    // Randomised batches across all three configurations.
    for (int it = 0; it < 15; it++) begin
      d    = $urandom_range(0, 2);
      n    = $urandom_range(1, 9);
      ul   = (n < 9) ? 1'b1 : 1'($urandom_range(0, 1));
      hold = $urandom_range(0, 3);
      for (int k = 0; k < n; k++) ops[k] = 16'($urandom);
      run_batch(d, n, ul, hold);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
